// File: rtl/mux_pkg.sv
// Shared types and constants for the 2:1 mux and its round-robin front end.
// Select encoding: 1 picks source x, 0 picks source y.
package mux_pkg;

    typedef logic [0:0] src_t;

    localparam src_t SEL_X = 1'b1;
    localparam src_t SEL_Y = 1'b0;

    // The only valid source wins; a tie or an idle cycle follows the priority bit.
    function automatic src_t rr_pick(input logic x_valid, input logic y_valid, input logic pri_x);
        src_t pick;
        pick = src_t'(pri_x);
        if (x_valid && !y_valid) pick = SEL_X;
        if (y_valid && !x_valid) pick = SEL_Y;
        return pick;
    endfunction

endpackage

// File: rtl/mux_rr_stage_if.sv
// Stream-side signal bundle of mux_rr_stage: two valid/ready sources, one
// valid/ready output, counter clear and bring-up counters.
interface mux_rr_stage_if
    import mux_pkg::*;
#(
    parameter int n  = 4,
    parameter int CW = 16
);

    logic          x_valid;
    logic          x_ready;
    logic [n-1:0]  x;
    logic          y_valid;
    logic          y_ready;
    logic [n-1:0]  y;
    logic          clr;
    src_t          s;
    logic          z_valid;
    logic          z_ready;
    logic [n-1:0]  z;
    src_t          z_src;
    logic [CW-1:0] cnt_x;
    logic [CW-1:0] cnt_y;

    modport master (
        output x_valid, x, y_valid, y, clr, z_ready,
        input  x_ready, y_ready, s, z_valid, z, z_src, cnt_x, cnt_y
    );

    modport slave (
        input  x_valid, x, y_valid, y, clr, z_ready,
        output x_ready, y_ready, s, z_valid, z, z_src, cnt_x, cnt_y
    );

endinterface

// File: rtl/mux.sv
// Plain 2:1 selector: z follows x when s selects x, otherwise y.
module mux
    import mux_pkg::*;
#(
    parameter int n = 4
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  src_t         s,
    output logic [n-1:0] z
);

    assign z = (s == SEL_X) ? x : y;

endmodule

// File: rtl/mux_rr_stage.sv
// Round-robin front end for mux: picks x or y, captures the winner into a
// one-entry output register, and counts accepted beats per source.
module mux_rr_stage
    import mux_pkg::*;
#(
    parameter int n  = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_rr_stage_if.slave io
);

    logic          pri_x_q,   pri_x_d;
    logic          z_valid_q, z_valid_d;
    logic [n-1:0]  z_q,       z_d;
    src_t          z_src_q,   z_src_d;
    logic [CW-1:0] cnt_x_q,   cnt_x_d;
    logic [CW-1:0] cnt_y_q,   cnt_y_d;

    src_t          sel;
    logic          space;
    logic          x_acc;
    logic          y_acc;
    logic          acc;
    logic [n-1:0]  mux_z;

    assign space = !z_valid_q || io.z_ready;
    assign sel   = rr_pick(io.x_valid, io.y_valid, pri_x_q);

    // Readies are gated by rst_n so nothing is granted while the register is held in reset.
    assign x_acc = rst_n && space && (sel == SEL_X) && io.x_valid;
    assign y_acc = rst_n && space && (sel == SEL_Y) && io.y_valid;
    assign acc   = x_acc || y_acc;

    mux #(.n(n)) u_mux (
        .x (io.x),
        .y (io.y),
        .s (sel),
        .z (mux_z)
    );

    always_comb begin
        // NOTE: every _d takes its _q value first so no branch can leave it unassigned and infer a latch.
        pri_x_d   = pri_x_q;
        z_valid_d = z_valid_q;
        z_d       = z_q;
        z_src_d   = z_src_q;
        cnt_x_d   = cnt_x_q;
        cnt_y_d   = cnt_y_q;

        if (acc) begin
            z_d       = mux_z;
            z_src_d   = sel;
            z_valid_d = 1'b1;
            pri_x_d   = !sel;
        end else if (z_valid_q && io.z_ready) begin
            z_valid_d = 1'b0;
        end

        if (io.clr) begin
            cnt_x_d = '0;
        end else if (x_acc && (cnt_x_q != '1)) begin
            cnt_x_d = cnt_x_q + CW'(1);
        end

        if (io.clr) begin
            cnt_y_d = '0;
        end else if (y_acc && (cnt_y_q != '1)) begin
            cnt_y_d = cnt_y_q + CW'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_x_q   <= 1'b1;
            z_valid_q <= 1'b0;
            z_q       <= '0;
            z_src_q   <= SEL_Y;
            cnt_x_q   <= '0;
            cnt_y_q   <= '0;
        end else begin
            pri_x_q   <= pri_x_d;
            z_valid_q <= z_valid_d;
            z_q       <= z_d;
            z_src_q   <= z_src_d;
            cnt_x_q   <= cnt_x_d;
            cnt_y_q   <= cnt_y_d;
        end
    end

    assign io.s       = sel;
    assign io.x_ready = x_acc;
    assign io.y_ready = y_acc;
    assign io.z_valid = z_valid_q;
    assign io.z       = z_q;
    assign io.z_src   = z_src_q;
    assign io.cnt_x   = cnt_x_q;
    assign io.cnt_y   = cnt_y_q;

endmodule

// File: doc/mux_rr_stage.md
# mux_rr_stage

Two-source round-robin stream stage that sits directly upstream of and drives the `mux` 2:1 selector. It accepts beats from two valid/ready sources, x and y, and generates the select `s` with round-robin fairness. The selected beat is captured into a one-entry registered output with valid/ready handshake. Per-source saturating beat counters support bring-up.

## Interface
- `n`, 4: data width of each source and of the output.
- `CW`, 16: width of each per-source beat counter.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset; the only reset.
- `x_valid`  in  1  source x beat present.
- `x_ready`  out  1  source x beat accepted this cycle.
- `x`  in  n  source x data.
- `y_valid`  in  1  source y beat present.
- `y_ready`  out  1  source y beat accepted this cycle.
- `y`  in  n  source y data.
- `clr`  in  1  synchronous clear of both counters.
- `s`  out  1  select: 1 = x, 0 = y. Same encoding as `mux`.
- `z_valid`  out  1  output register holds a beat.
- `z_ready`  in  1  downstream accepts the beat.
- `z`  out  n  registered selected data.
- `z_src`  out  1  source of the held beat: 1 = x, 0 = y.
- `cnt_x`  out  CW  beats accepted from x, saturating.
- `cnt_y`  out  CW  beats accepted from y, saturating.

## Operation
- Internal state:
  - `pri_x` (1 = x wins a tie).
  - Output register `{z_valid, z, z_src}`.
  - `cnt_x`, `cnt_y`.
- `space = !z_valid || z_ready`.
- Select (combinational):
  - Both valid: `s = pri_x`.
  - Only x valid: `s = 1`.
  - Only y valid: `s = 0`.
  - Neither valid: `s = pri_x`.
- Acceptance:
  - `x_ready = space && s && x_valid`.
  - `y_ready = space && !s && y_valid`.
  - At most one source is accepted per cycle.
  - `acc = x_ready || y_ready`.
- On `acc`:
  - z ← `mux` output.
  - `z_src` ← `s`.
  - `z_valid` ← 1.
  - `pri_x` ← `!s`, so the loser of a tie wins next time.
- On `z_valid && z_ready && !acc`: `z_valid` ← 0; `z` and `z_src` hold.
- Drain and refill in the same cycle: the new beat replaces the old one with no bubble. `z_valid` stays 1.
- `pri_x` changes only on `acc`. A stalled grant does not rotate priority.
- Counters:
  - On `x_ready`, `cnt_x` increments, saturating at all-ones. `cnt_y` is identical on `y_ready`.
  - `clr` sets both counters to 0 and wins over a same-cycle increment.
- Inputs must hold data while valid and not ready. The block does not check this.

## Timing
- Reset (async assert, sync-to-clk release is the integrator's job). All values below hold while `rst_n` is low:
  - `z_valid=0`, `z=0`, `z_src=0`.
  - `cnt_x=0`, `cnt_y=0`.
  - `pri_x=1`.
  - `x_ready=y_ready=0`; readies are forced low while `rst_n` is low.
- Latency: a beat accepted at edge k appears on `z` with `z_valid=1` after edge k. That is one cycle.
- Throughput: one beat per cycle while `z_ready=1`.
- `s`, `x_ready`, and `y_ready` are combinational from the valids, `pri_x`, `z_valid`, and `z_ready`. There is no path from `x` or `y` data to any ready.
- `z`, `z_valid`, `z_src`, and the counters are registered. There is no combinational path from inputs to them.
- Reset mid-transfer: the held beat is discarded and round-robin restarts with x preferred.

## Structure
- Shared package `mux_pkg`:
  - `localparam SEL_X = 1'b1`, `SEL_Y = 1'b0`.
  - Typedef `src_t` (1-bit source id) for `s` and `z_src`.
- One sub-module: instantiate the existing `mux` with `n`, `x`, `y`, `s`. Its `z` feeds the output register.
- Counters are inline. No separate FIFO. Register and counter logic uses `always_ff` with async reset.

## Test plan
- Reset release, n=4, x_valid=y_valid=1 every cycle, z_ready=1, x=4'hA, y=4'h5 → z sequence A,5,A,5 (z_src 1,0,1,0); cnt_x=cnt_y=2 after 4 beats.
- Backpressure: z holds 4'hA, z_ready=0 for 3 cycles, both valid → x_ready=y_ready=0, z stable, s constant; release → next beat is y (4'h5), no loss or duplicate.
- Single source: only y_valid=1 for 5 beats → s=0, all accepted back-to-back, pri_x=1 afterwards; then both valid → x granted first.
- Counter saturation, CW=4: 17 x beats → cnt_x=4'hF; assert clr together with one x beat → cnt_x=0.
- Async reset asserted mid-cycle while z_valid=1 → z_valid, z, and counters go to 0 immediately with no clock edge; readies go low.
- Random valid/ready over 10k cycles with a scoreboard → output order equals the accepted order, and no source ever waits more than one grant while the other is valid.
